// File: rtl/systolic_result_collector.sv
`timescale 1ns/1ps
// systolic_result_collector
//
// Collects the N1 per-row result streams that leave the systolic MAC array
// and serialises them into a single valid/ready stream. Every element carries
// its row-major address (r*M + c) in the M x M result matrix. Each row has its
// own FIFO. The FIFOs are drained by a round-robin arbiter into one output
// register.
//
// A row's incoming beat is captured first and then written into the FIFO on
// the following edge. The beat is tagged with its address at that write.
// An element sampled on edge e therefore appears on m_* at edge e+2.
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset
//   d_in      N1 packed row results, row i at [i*D_W_ACC +: D_W_ACC]
//   valid_in  per-row result valid
//   m_data    output element
//   m_addr    row-major element address
//   m_valid   output element valid
//   m_ready   downstream accept
//   m_last    high with the final element of an M*M frame
//   done      one-cycle pulse after the m_last handshake
//   overflow  sticky per-row flag, set when a beat was dropped
//   busy      any buffered element or m_valid high
module systolic_result_collector #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int N2      = 4,
  parameter int M       = 8,
  parameter int FIFO_D  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N1*D_W_ACC-1:0]     d_in,
  input  logic [N1-1:0]             valid_in,
  output logic [D_W_ACC-1:0]        m_data,
  output logic [$clog2(M*M)-1:0]    m_addr,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      done,
  output logic [N1-1:0]             overflow,
  output logic                      busy
);

  localparam int AW  = $clog2(M*M);
  localparam int TCN = M / N2;
  localparam int TRN = M / N1;
  localparam int KW  = (N2 > 1) ? $clog2(N2) : 1;
  localparam int TCW = (TCN > 1) ? $clog2(TCN) : 1;
  localparam int TRW = (TRN > 1) ? $clog2(TRN) : 1;
  localparam int RW  = (N1 > 1) ? $clog2(N1) : 1;
  localparam int PW  = $clog2(FIFO_D);
  localparam int EW  = D_W_ACC + AW;

  logic [N1-1:0]      stageValid_q;
  logic [D_W_ACC-1:0] stageData_q [N1];
  logic [EW-1:0]      fifoMem_q [N1][FIFO_D];
  logic [PW:0]        wrPtr_q [N1];
  logic [PW:0]        rdPtr_q [N1];
  logic [KW-1:0]      beatK_q [N1];
  logic [TCW-1:0]     tileCol_q [N1];
  logic [TRW-1:0]     tileRow_q [N1];
  logic [RW-1:0]      rrPtr_q;
  logic [D_W_ACC-1:0] outData_q;
  logic [AW-1:0]      outAddr_q;
  logic               outValid_q;
  logic               outLast_q;
  logic [AW-1:0]      frameCnt_q;
  logic               done_q;
  logic [N1-1:0]      overflow_q;

  logic [N1-1:0]      fifoEmpty;
  logic [N1-1:0]      fifoFull;
  logic [N1-1:0]      pushOk;
  logic [N1-1:0]      pop;
  logic [AW-1:0]      tagAddr [N1];
  logic [RW-1:0]      grant;
  logic [RW-1:0]      idx;
  logic               found;
  logic               load;
  logic [EW-1:0]      headEntry;

  // FIFO status and address tags. The pointers carry one extra wrap bit, so
  // full and empty can be told apart when the index bits are equal. Inside a
  // tile the last PE emits first, so beat k lands in column N2-1-k.
  always_comb begin
    for (int i = 0; i < N1; i++) begin
      fifoEmpty[i] = (wrPtr_q[i] == rdPtr_q[i]);
      fifoFull[i]  = (wrPtr_q[i][PW] != rdPtr_q[i][PW]) &&
                     (wrPtr_q[i][PW-1:0] == rdPtr_q[i][PW-1:0]);
      tagAddr[i]   = AW'((int'(tileRow_q[i]) * N1 + i) * M +
                         int'(tileCol_q[i]) * N2 + (N2 - 1 - int'(beatK_q[i])));
    end
  end

  // Round-robin grant: pick the first non-empty row, searching upward from
  // the pointer. The output register loads whenever it is free or is being
  // emptied this cycle. A push to a full FIFO still succeeds if that row is
  // popped in the same cycle.
  always_comb begin
    grant = rrPtr_q;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < N1; j++) begin
      idx = RW'((int'(rrPtr_q) + j) % N1);
      if (!found && !fifoEmpty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    load      = found && (!outValid_q || m_ready);
    headEntry = fifoMem_q[grant][rdPtr_q[grant][PW-1:0]];
    for (int i = 0; i < N1; i++) begin
      pop[i]    = load && (grant == RW'(i));
      pushOk[i] = stageValid_q[i] && (!fifoFull[i] || pop[i]);
    end
  end

  // FIFO storage. It has no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N1; i++) begin
      if (pushOk[i]) begin
        fifoMem_q[i][wrPtr_q[i][PW-1:0]] <= {stageData_q[i], tagAddr[i]};
      end
    end
  end

  // Input capture, FIFO pointers, per-row tile counters, arbiter pointer,
  // output register and frame tracking. The tile counters move only on an
  // accepted write, so a dropped beat leaves the row's tagging unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      stageValid_q <= '0;
      for (int i = 0; i < N1; i++) begin
        stageData_q[i] <= '0;
        wrPtr_q[i]     <= '0;
        rdPtr_q[i]     <= '0;
        beatK_q[i]     <= '0;
        tileCol_q[i]   <= '0;
        tileRow_q[i]   <= '0;
      end
      rrPtr_q    <= '0;
      outData_q  <= '0;
      outAddr_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      frameCnt_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= '0;
    end else begin
      stageValid_q <= valid_in;
      for (int i = 0; i < N1; i++) begin
        stageData_q[i] <= d_in[i*D_W_ACC +: D_W_ACC];
        if (pushOk[i]) begin
          wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
          if (int'(beatK_q[i]) == N2 - 1) begin
            beatK_q[i] <= '0;
            if (int'(tileCol_q[i]) == TCN - 1) begin
              tileCol_q[i] <= '0;
              if (int'(tileRow_q[i]) == TRN - 1) begin
                tileRow_q[i] <= '0;
              end else begin
                tileRow_q[i] <= tileRow_q[i] + 1'b1;
              end
            end else begin
              tileCol_q[i] <= tileCol_q[i] + 1'b1;
            end
          end else begin
            beatK_q[i] <= beatK_q[i] + 1'b1;
          end
        end else if (stageValid_q[i]) begin
          overflow_q[i] <= 1'b1;
        end
        if (pop[i]) begin
          rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
        end
      end

      if (load) begin
        outValid_q <= 1'b1;
        outData_q  <= headEntry[EW-1:AW];
        outAddr_q  <= headEntry[AW-1:0];
        outLast_q  <= (int'(frameCnt_q) == M*M - 1);
        rrPtr_q    <= (int'(grant) == N1 - 1) ? '0 : grant + 1'b1;
        if (int'(frameCnt_q) == M*M - 1) begin
          frameCnt_q <= '0;
        end else begin
          frameCnt_q <= frameCnt_q + 1'b1;
        end
      end else if (outValid_q && m_ready) begin
        outValid_q <= 1'b0;
        outLast_q  <= 1'b0;
      end

      done_q <= outValid_q && m_ready && outLast_q;
    end
  end

  assign m_data   = outData_q;
  assign m_addr   = outAddr_q;
  assign m_valid  = outValid_q;
  assign m_last   = outLast_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign busy     = outValid_q || (|stageValid_q) || (|(~fifoEmpty));

endmodule
